// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mul_state_t;

    typedef logic [1:0] fwd_sel_t;
    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_WB  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;

    // Memory stage is younger than writeback, so it wins on a double match.
    function automatic fwd_sel_t fwd_select(
        input logic [4:0] src,
        input logic       we_m,
        input logic [4:0] wa_m,
        input logic       we_w,
        input logic [4:0] wa_w
    );
        if (we_m && wa_m != 5'd0 && wa_m == src) return FWD_MEM;
        if (we_w && wa_w != 5'd0 && wa_w == src) return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_mul_seq.sv
// Multi-cycle multiply sequencer: holds the front of the pipe while a multiply
// occupies execute and flags the cycle its result is valid.
module mul_seq
    import hazard_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic mul_en_e,
    output logic mul_stall,
    output logic mul_busy,
    output logic mul_done
);

    mul_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mul_stall = 1'b0;
        mul_done  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mul_en_e) begin
                    if (MUL_LATENCY > 1) begin
                        mul_stall = 1'b1;
                        state_d   = BUSY;
                        cnt_d     = 4'(MUL_LATENCY - 2);
                    end else begin
                        mul_done = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    mul_stall = 1'b1;
                    cnt_d     = cnt_q - 4'd1;
                end else begin
                    mul_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // An in-flight multiply aborted by reset must not report completion.
        if (reset) begin
            mul_stall = 1'b0;
            mul_done  = 1'b0;
        end
    end

    assign mul_busy = (state_q == BUSY) && !reset;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use detection, redirect flushes, multiply
// stall merge, execute operand forwarding and stall/flush performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  reg_read_addr1_d,
    input  logic [4:0]  reg_read_addr2_d,
    input  logic        rs1_used_d,
    input  logic        rs2_used_d,
    input  logic [4:0]  reg_read_addr1_e,
    input  logic [4:0]  reg_read_addr2_e,
    input  logic        reg_write_en_e,
    input  logic        dmem_read_en_e,
    input  logic        mul_en_e,
    input  logic [4:0]  reg_write_addr_e,
    input  logic        reg_write_en_m,
    input  logic [4:0]  reg_write_addr_m,
    input  logic        reg_write_en_w,
    input  logic [4:0]  reg_write_addr_w,
    input  logic        redirect_e,
    output logic        stall_f,
    output logic        stall_d,
    output logic        hold_e,
    output logic        flush_d,
    output logic        flush_e,
    output logic        flush_m,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic        mul_busy,
    output logic        mul_done,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    logic        mul_stall;
    logic        lu;
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_events_q, flush_events_d;

    mul_seq #(
        .MUL_LATENCY(MUL_LATENCY)
    ) u_mul_seq (
        .clk      (clk),
        .reset    (reset),
        .mul_en_e (mul_en_e),
        .mul_stall(mul_stall),
        .mul_busy (mul_busy),
        .mul_done (mul_done)
    );

    assign lu = dmem_read_en_e && reg_write_en_e && (reg_write_addr_e != 5'd0) &&
                ((rs1_used_d && reg_read_addr1_d == reg_write_addr_e) ||
                 (rs2_used_d && reg_read_addr2_d == reg_write_addr_e));

    always_comb begin
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        hold_e    = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        flush_m   = 1'b0;
        fwd_a_sel = FWD_RF;
        fwd_b_sel = FWD_RF;
        if (!reset) begin
            if (mul_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                hold_e  = 1'b1;
                flush_m = 1'b1;
            end else if (redirect_e) begin
                // Decode holds a wrong-path instruction, so its load-use is moot.
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (lu) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
            fwd_a_sel = fwd_select(reg_read_addr1_e, reg_write_en_m, reg_write_addr_m,
                                   reg_write_en_w, reg_write_addr_w);
            fwd_b_sel = fwd_select(reg_read_addr2_e, reg_write_en_m, reg_write_addr_m,
                                   reg_write_en_w, reg_write_addr_w);
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q + (stall_f ? 32'd1 : 32'd0);
        flush_events_d = flush_events_q + ((flush_d || flush_e) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: combinational vector table plus multiply,
// reset-abort and counter-wrap sequences.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  a1d, a2d, a1e, a2e, wa_e, wa_m, wa_w;
    logic        u1, u2, we_e, ld_e, mul_e, we_m, we_w, redir;

    logic        stall_f, stall_d, hold_e, flush_d, flush_e, flush_m, mul_busy, mul_done;
    logic [1:0]  fa, fb;
    logic [31:0] stall_cycles, flush_events;

    logic        s1_stall_f, s1_stall_d, s1_hold_e, s1_flush_d, s1_flush_e, s1_flush_m;
    logic        s1_busy, s1_done;
    logic [1:0]  s1_fa, s1_fb;
    logic [31:0] s1_sc, s1_fe;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MUL_LATENCY(4)) dut (
        .clk(clk), .reset(reset),
        .reg_read_addr1_d(a1d), .reg_read_addr2_d(a2d),
        .rs1_used_d(u1), .rs2_used_d(u2),
        .reg_read_addr1_e(a1e), .reg_read_addr2_e(a2e),
        .reg_write_en_e(we_e), .dmem_read_en_e(ld_e), .mul_en_e(mul_e),
        .reg_write_addr_e(wa_e),
        .reg_write_en_m(we_m), .reg_write_addr_m(wa_m),
        .reg_write_en_w(we_w), .reg_write_addr_w(wa_w),
        .redirect_e(redir),
        .stall_f(stall_f), .stall_d(stall_d), .hold_e(hold_e),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
        .fwd_a_sel(fa), .fwd_b_sel(fb),
        .mul_busy(mul_busy), .mul_done(mul_done),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    hazard_ctrl #(.MUL_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .reg_read_addr1_d(a1d), .reg_read_addr2_d(a2d),
        .rs1_used_d(u1), .rs2_used_d(u2),
        .reg_read_addr1_e(a1e), .reg_read_addr2_e(a2e),
        .reg_write_en_e(we_e), .dmem_read_en_e(ld_e), .mul_en_e(mul_e),
        .reg_write_addr_e(wa_e),
        .reg_write_en_m(we_m), .reg_write_addr_m(wa_m),
        .reg_write_en_w(we_w), .reg_write_addr_w(wa_w),
        .redirect_e(redir),
        .stall_f(s1_stall_f), .stall_d(s1_stall_d), .hold_e(s1_hold_e),
        .flush_d(s1_flush_d), .flush_e(s1_flush_e), .flush_m(s1_flush_m),
        .fwd_a_sel(s1_fa), .fwd_b_sel(s1_fb),
        .mul_busy(s1_busy), .mul_done(s1_done),
        .stall_cycles(s1_sc), .flush_events(s1_fe)
    );

    typedef struct packed {
        logic [4:0] a1d, a2d;
        logic       u1, u2;
        logic [4:0] a1e, a2e;
        logic       we_e, ld_e;
        logic [4:0] wa_e;
        logic       we_m;
        logic [4:0] wa_m;
        logic       we_w;
        logic [4:0] wa_w;
        logic       redir;
        logic [5:0] ctl;   // {stall_f, stall_d, hold_e, flush_d, flush_e, flush_m}
        logic [1:0] fa, fb;
    } vec_t;

    function automatic logic [5:0] ctl();
        return {stall_f, stall_d, hold_e, flush_d, flush_e, flush_m};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        a1d = '0; a2d = '0; u1 = 1'b0; u2 = 1'b0; a1e = '0; a2e = '0;
        we_e = 1'b0; ld_e = 1'b0; mul_e = 1'b0; wa_e = '0;
        we_m = 1'b0; wa_m = '0; we_w = 1'b0; wa_w = '0; redir = 1'b0;
    endtask

    // Load x5 in execute, decode reads x5 on rs1.
    task automatic set_lu();
        ld_e = 1'b1; we_e = 1'b1; wa_e = 5'd5; a1d = 5'd5; u1 = 1'b1; a2d = 5'd1; u2 = 1'b1;
    endtask

    vec_t vecs[13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] sc0, fe0;
        logic [5:0]  mexp_ctl[9];
        logic        mexp_done[9], mexp_busy[9];

        //         a1d   a2d  u1 u2  a1e   a2e  we ld wa_e  wm  wa_m wwb wa_w  rd  ctl        fa     fb
        vecs[0]  = '{5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 6'b000000, 2'b00, 2'b00};
        vecs[1]  = '{5'd5, 5'd1, 1, 1, 5'd0, 5'd0, 1, 1, 5'd5, 0, 5'd0, 0, 5'd0, 0, 6'b110010, 2'b00, 2'b00};
        vecs[2]  = '{5'd1, 5'd5, 1, 1, 5'd0, 5'd0, 1, 1, 5'd5, 0, 5'd0, 0, 5'd0, 0, 6'b110010, 2'b00, 2'b00};
        vecs[3]  = '{5'd5, 5'd1, 0, 1, 5'd0, 5'd0, 1, 1, 5'd5, 0, 5'd0, 0, 5'd0, 0, 6'b000000, 2'b00, 2'b00};
        vecs[4]  = '{5'd0, 5'd0, 1, 1, 5'd0, 5'd0, 1, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 6'b000000, 2'b00, 2'b00};
        vecs[5]  = '{5'd5, 5'd1, 1, 1, 5'd0, 5'd0, 1, 0, 5'd5, 0, 5'd0, 0, 5'd0, 0, 6'b000000, 2'b00, 2'b00};
        vecs[6]  = '{5'd5, 5'd1, 1, 1, 5'd0, 5'd0, 0, 1, 5'd5, 0, 5'd0, 0, 5'd0, 0, 6'b000000, 2'b00, 2'b00};
        vecs[7]  = '{5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 6'b000110, 2'b00, 2'b00};
        vecs[8]  = '{5'd5, 5'd1, 1, 1, 5'd0, 5'd0, 1, 1, 5'd5, 0, 5'd0, 0, 5'd0, 1, 6'b000110, 2'b00, 2'b00};
        vecs[9]  = '{5'd0, 5'd0, 0, 0, 5'd3, 5'd7, 0, 0, 5'd0, 1, 5'd3, 1, 5'd3, 0, 6'b000000, 2'b10, 2'b00};
        vecs[10] = '{5'd0, 5'd0, 0, 0, 5'd3, 5'd7, 0, 0, 5'd0, 0, 5'd3, 1, 5'd3, 0, 6'b000000, 2'b01, 2'b00};
        vecs[11] = '{5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 5'd0, 1, 5'd0, 0, 6'b000000, 2'b00, 2'b00};
        vecs[12] = '{5'd0, 5'd0, 0, 0, 5'd4, 5'd9, 0, 0, 5'd0, 1, 5'd4, 1, 5'd9, 0, 6'b000000, 2'b10, 2'b01};

        // Reset with every hazard/forward condition active: outputs forced low.
        idle_inputs();
        reset = 1'b1;
        set_lu(); redir = 1'b1; a1e = 5'd3; we_m = 1'b1; wa_m = 5'd3; mul_e = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("reset_ctl", 32'(ctl()), 32'd0);
        check("reset_fwd_a", 32'(fa), 32'd0);
        check("reset_busy_done", 32'({mul_busy, mul_done}), 32'd0);
        idle_inputs();
        reset = 1'b0;
        #1;
        check("reset_stall_cycles", stall_cycles, 32'd0);
        check("reset_flush_events", flush_events, 32'd0);

        // Load-use: one stall cycle, then the load leaves execute.
        set_lu(); #1;
        check("lu_ctl", 32'(ctl()), 32'b110010);
        @(posedge clk); @(negedge clk);
        idle_inputs(); a1d = 5'd5; u1 = 1'b1; we_m = 1'b1; wa_m = 5'd5; #1;
        check("lu_cleared", 32'(ctl()), 32'd0);
        check("lu_stall_cycles", stall_cycles, 32'd1);
        check("lu_flush_events", flush_events, 32'd1);

        // Combinational vector table.
        for (int unsigned i = 0; i < 13; i++) begin
            @(negedge clk);
            idle_inputs();
            a1d = vecs[i].a1d; a2d = vecs[i].a2d; u1 = vecs[i].u1; u2 = vecs[i].u2;
            a1e = vecs[i].a1e; a2e = vecs[i].a2e; we_e = vecs[i].we_e; ld_e = vecs[i].ld_e;
            wa_e = vecs[i].wa_e; we_m = vecs[i].we_m; wa_m = vecs[i].wa_m;
            we_w = vecs[i].we_w; wa_w = vecs[i].wa_w; redir = vecs[i].redir;
            #1;
            check($sformatf("vec%0d_ctl", i), 32'(ctl()), 32'(vecs[i].ctl));
            check($sformatf("vec%0d_fwd", i), 32'({fa, fb}), 32'({vecs[i].fa, vecs[i].fb}));
        end

        // Two back-to-back multiplies (latency 4) then idle; redirect and a
        // load-use are presented during the first multiply's stall cycles.
        mexp_ctl  = '{6'b111001, 6'b111001, 6'b111001, 6'b000000,
                      6'b111001, 6'b111001, 6'b111001, 6'b000000, 6'b000000};
        mexp_done = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
        mexp_busy = '{0, 1, 1, 1, 0, 1, 1, 1, 0};
        for (int unsigned c = 0; c < 9; c++) begin
            @(negedge clk);
            idle_inputs();
            mul_e = (c < 8);
            if (c < 3) begin set_lu(); redir = 1'b1; end
            #1;
            check($sformatf("mul_c%0d_ctl", c), 32'(ctl()), 32'(mexp_ctl[c]));
            check($sformatf("mul_c%0d_done", c), 32'(mul_done), 32'(mexp_done[c]));
            check($sformatf("mul_c%0d_busy", c), 32'(mul_busy), 32'(mexp_busy[c]));
            if (c == 0) begin
                check("mul1_done", 32'(s1_done), 32'd1);
                check("mul1_nostall", 32'({s1_stall_f, s1_hold_e, s1_flush_m, s1_busy}), 32'd0);
            end
        end

        // Redirect overriding a load-use: one flush event, no stall.
        @(negedge clk);
        sc0 = stall_cycles; fe0 = flush_events;
        idle_inputs(); set_lu(); redir = 1'b1; #1;
        check("redir_lu_ctl", 32'(ctl()), 32'b000110);
        @(posedge clk); @(negedge clk);
        idle_inputs(); #1;
        check("redir_flush_events", flush_events, fe0 + 32'd1);
        check("redir_stall_cycles", stall_cycles, sc0);

        // Reset one cycle into a multiply aborts it without mul_done.
        @(negedge clk);
        idle_inputs(); mul_e = 1'b1;
        @(negedge clk); #1;
        check("abort_busy_before", 32'(mul_busy), 32'd1);
        reset = 1'b1; #1;
        check("abort_in_reset", 32'({mul_busy, mul_done, stall_f, hold_e}), 32'd0);
        @(negedge clk);
        reset = 1'b0; mul_e = 1'b0; #1;
        check("abort_idle", 32'({mul_busy, mul_done}), 32'd0);
        check("abort_counters", stall_cycles | flush_events, 32'd0);
        for (int unsigned c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            check($sformatf("abort_nodone%0d", c), 32'({mul_busy, mul_done}), 32'd0);
        end

        // Stall counter wraps from all-ones to zero.
        @(negedge clk);
        force dut.stall_cycles_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cycles_q;
        set_lu(); #1;
        check("wrap_stall", 32'(stall_f), 32'd1);
        @(posedge clk); @(negedge clk);
        idle_inputs(); #1;
        check("wrap_stall_cycles", stall_cycles, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
